// File: rtl/seq_booth_mult.sv
// Multi-cycle radix-2 Booth multiplier. Operands are widened by one bit so signed and unsigned
// inputs share a single signed core; the product and overflow flag are held until the next result.
module seq_booth_mult #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 overflow,
    output logic [1:0]           dbg_state
);
    localparam int CW = $clog2(WIDTH + 1);

    // Handshake: start is accepted only on an en=1 edge in IDLE; busy covers the whole run and
    // done is a single pulse that persists across en=0 cycles until the next en=1 edge.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH+1:0]     m_q, m_d;
    logic [WIDTH+1:0]     acc_q, acc_d;
    logic [WIDTH:0]       mq_q, mq_d;
    logic                 qm1_q, qm1_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 sgn_q, sgn_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic                 ovf_q, ovf_d;

    logic [WIDTH+1:0]     sum;
    logic [2*WIDTH-1:0]   prod_next;
    logic                 hi_ones, hi_zeros;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        busy_d  = busy_q;
        done_d  = done_q;
        prod_d  = prod_q;
        ovf_d   = ovf_q;

        sum = acc_q;
        case ({mq_q[0], qm1_q})
            2'b01:   sum = acc_q + m_q;
            2'b10:   sum = acc_q - m_q;
            default: sum = acc_q;
        endcase

        // Low 2*WIDTH bits of the shifted {A,Q}: A[WIDTH-2:0] comes from sum[WIDTH-1:1].
        prod_next = {sum[WIDTH-1:0], mq_q[WIDTH:1]};
        hi_ones   = &prod_next[2*WIDTH-1:WIDTH-1];
        hi_zeros  = ~|prod_next[2*WIDTH-1:WIDTH-1];

        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = {{2{is_signed & a[WIDTH-1]}}, a};
                    mq_d    = {is_signed & b[WIDTH-1], b};
                    acc_d   = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                    sgn_d   = is_signed;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = {sum[WIDTH+1], sum[WIDTH+1:1]};
                mq_d  = {sum[0], mq_q[WIDTH:1]};
                qm1_d = mq_q[0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH)) begin
                    prod_d  = prod_next;
                    ovf_d   = sgn_q ? !(hi_ones || hi_zeros) : (|prod_next[2*WIDTH-1:WIDTH]);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            prod_q  <= '0;
            ovf_q   <= 1'b0;
        end else if (en) begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            prod_q  <= prod_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign product   = prod_q;
    assign overflow  = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_booth_mult.sv
// Directed bench for seq_booth_mult: a vector table for the 32-bit instance plus hand-written
// stall, ignore, reset and 8-bit sequences.
module tb_seq_booth_mult;

    logic        clk = 1'b0;
    logic        reset, en, start, is_signed;
    logic [31:0] a, b;
    logic        busy, done, overflow;
    logic [63:0] product;
    logic [1:0]  dbg_state;

    logic        reset8, start8, is_signed8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, overflow8;
    logic [15:0] product8;
    logic [1:0]  dbg_state8;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] exp_q[$];
    logic [63:0] r_prod;
    logic        r_ovf;
    int          r_lat, r_busy_cnt;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
        logic        ovf;
    } vec_t;

    vec_t vecs[15];

    seq_booth_mult #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .en(en), .start(start), .is_signed(is_signed),
        .a(a), .b(b), .busy(busy), .done(done), .product(product),
        .overflow(overflow), .dbg_state(dbg_state)
    );

    seq_booth_mult #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset8), .en(en), .start(start8), .is_signed(is_signed8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .product(product8),
        .overflow(overflow8), .dbg_state(dbg_state8)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one 32-bit multiply; optional en=0 window and extra start pulses while busy.
    task automatic run32(input logic sgn, input logic [31:0] aa, input logic [31:0] bb,
                         input int stall_at, input int stall_len, input int poke_at);
        @(negedge clk);
        is_signed = sgn; a = aa; b = bb; start = 1'b1; en = 1'b1;
        @(negedge clk);
        start = 1'b0; is_signed = ~sgn; a = ~aa; b = bb ^ 32'h5a5a_a5a5;
        r_lat = 0;
        r_busy_cnt = busy ? 1 : 0;
        while (!done && r_lat < 200) begin
            en = (r_lat >= stall_at && r_lat < stall_at + stall_len) ? 1'b0 : 1'b1;
            start = (r_lat == poke_at) || (stall_len > 0 && r_lat == stall_at);
            if (start) begin
                a = 32'd11; b = 32'd0;
            end
            @(negedge clk);
            r_lat++;
            if (busy) r_busy_cnt++;
        end
        start = 1'b0; en = 1'b1;
        r_prod = product; r_ovf = overflow;
    endtask

    task automatic run8(input logic sgn, input logic [7:0] aa, input logic [7:0] bb);
        @(negedge clk);
        is_signed8 = sgn; a8 = aa; b8 = bb; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'h00; b8 = 8'hff;
        r_lat = 0;
        while (!done8 && r_lat < 100) begin
            @(negedge clk);
            r_lat++;
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'd5,         32'hFFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFDD, 1'b0};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF4, 32'hFFFF_FFFC, 64'h0000_0000_0000_0030, 1'b0};
        vecs[2]  = '{1'b1, 32'hFFFF_FFF7, 32'd5,         64'hFFFF_FFFF_FFFF_FFD3, 1'b0};
        vecs[3]  = '{1'b0, 32'hFFFF_FFFF, 32'd2,         64'h0000_0001_FFFF_FFFE, 1'b1};
        vecs[4]  = '{1'b1, 32'hFFFF_FFFF, 32'd2,         64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
        vecs[5]  = '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1};
        vecs[6]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1};
        vecs[7]  = '{1'b1, 32'd0,         32'hFFFF_FFFB, 64'h0,                   1'b0};
        vecs[8]  = '{1'b0, 32'h1234_5678, 32'd0,         64'h0,                   1'b0};
        vecs[9]  = '{1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b1};
        vecs[10] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0};
        vecs[11] = '{1'b0, 32'h0001_0000, 32'h0000_FFFF, 64'h0000_0000_FFFF_0000, 1'b0};
        vecs[12] = '{1'b1, 32'h0001_0000, 32'h0000_8000, 64'h0000_0000_8000_0000, 1'b1};
        vecs[13] = '{1'b1, 32'hFFFF_0000, 32'h0000_8000, 64'hFFFF_FFFF_8000_0000, 1'b0};
        vecs[14] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1};

        reset = 1'b0; reset8 = 1'b0; en = 1'b1;
        start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        start8 = 1'b0; is_signed8 = 1'b0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_product", product, 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);
        chk("reset_state", 64'(dbg_state), 64'd0);
        chk("reset8_product", 64'(product8), 64'd0);
        reset = 1'b1; reset8 = 1'b1;

        // Table vectors; consecutive entries also exercise start in the cycle after done.
        for (int i = 0; i < 15; i++) begin
            exp_q.push_back(vecs[i].p);
            run32(vecs[i].sgn, vecs[i].a, vecs[i].b, -1, 0, -1);
            chk($sformatf("v%0d_latency", i), 64'(r_lat), 64'd33);
            chk($sformatf("v%0d_busy_cycles", i), 64'(r_busy_cnt), 64'd33);
            chk($sformatf("v%0d_product", i), r_prod, exp_q.pop_front());
            chk($sformatf("v%0d_overflow", i), 64'(r_ovf), 64'(vecs[i].ovf));
        end

        // Ten en=0 cycles mid-run, with start pulses while busy (one during the stall).
        run32(1'b1, 32'd5, 32'hFFFF_FFF9, 12, 10, 5);
        chk("stall_latency", 64'(r_lat), 64'd43);
        chk("stall_busy_cycles", 64'(r_busy_cnt), 64'd43);
        chk("stall_product", r_prod, 64'hFFFF_FFFF_FFFF_FFDD);
        chk("stall_overflow", 64'(r_ovf), 64'd0);

        // done must survive en=0; a start while in DONE is ignored.
        run32(1'b0, 32'd3, 32'd4, -1, 0, -1);
        chk("hold_product", r_prod, 64'd12);
        en = 1'b0;
        repeat (3) @(negedge clk);
        chk("done_held_en0", 64'(done), 64'd1);
        en = 1'b1; start = 1'b1; a = 32'd11; b = 32'd0;
        @(negedge clk);
        start = 1'b0;
        chk("done_pulse_end", 64'(done), 64'd0);
        @(negedge clk);
        chk("start_in_done_ignored", 64'(busy), 64'd0);
        chk("product_held", product, 64'd12);

        // Reset in the middle of a run.
        @(negedge clk);
        is_signed = 1'b0; a = 32'd100; b = 32'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("midrun_reset_busy", 64'(busy), 64'd0);
        chk("midrun_reset_done", 64'(done), 64'd0);
        chk("midrun_reset_product", product, 64'd0);
        run32(1'b0, 32'd10, 32'd1, -1, 0, -1);
        chk("after_reset_latency", 64'(r_lat), 64'd33);
        chk("after_reset_product", r_prod, 64'd10);

        // Reset while done is high.
        run32(1'b1, 32'hFFFF_FFFD, 32'd3, -1, 0, -1);
        chk("pre_reset_product", r_prod, 64'hFFFF_FFFF_FFFF_FFF7);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("reset_in_done_done", 64'(done), 64'd0);
        chk("reset_in_done_product", product, 64'd0);

        // 8-bit instance: interrupted run, then -128 * 127.
        @(negedge clk);
        is_signed8 = 1'b1; a8 = 8'h80; b8 = 8'h7F; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        reset8 = 1'b0;
        @(negedge clk);
        reset8 = 1'b1;
        chk("w8_midrun_reset_busy", 64'(busy8), 64'd0);
        run8(1'b1, 8'h80, 8'h7F);
        chk("w8_latency", 64'(r_lat), 64'd9);
        chk("w8_product", 64'(product8), 64'h0000_0000_0000_C080);
        chk("w8_overflow", 64'(overflow8), 64'd1);
        run8(1'b0, 8'hFF, 8'hFF);
        chk("w8_unsigned_product", 64'(product8), 64'h0000_0000_0000_FE01);
        chk("w8_unsigned_overflow", 64'(overflow8), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
